// File: rtl/servo_seq.sv
// servo_seq: plays a stored sequence of servo positions as per-channel PWM.
// Each step fetches NUM_CH positions from memory and holds them for a number
// of frames. Optional rate limiting is enabled by defining the macro
// SERVO_SEQ_SLEW_EN (positions then move by at most SLEW_STEP per frame).
module servo_seq #(
  parameter int NUM_CH     = 3,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int CLK_HZ     = 50000000,
  parameter int FRAME_US   = 20000,
  parameter int SLEW_STEP  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  loop,
  input  logic [ADDR_WIDTH-1:0] seq_len,
  input  logic [7:0]            hold_frames,
  output logic                  mem_rd,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic [NUM_CH-1:0]     pwm_out,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] step_idx,
  output logic                  done
);
  localparam int DIV    = (CLK_HZ / 1000000 > 0) ? CLK_HZ / 1000000 : 1;
  localparam int TICK_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int US_W   = $clog2(FRAME_US);
  // Widest possible pulse; from this point on every channel is low, so the
  // next step is fetched here and is ready before the frame boundary.
  localparam int PW_MAX = 1000 + 4 * (2**DATA_WIDTH - 1);
  localparam int CH_W   = $clog2(NUM_CH + 1);

  if (FRAME_US <= PW_MAX + NUM_CH + 2 || SLEW_STEP < 1) begin : g_bad_cfg
    $error("servo_seq: FRAME_US too short or SLEW_STEP < 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_RUN} state_t;

  state_t                state_q, state_d;
  logic [TICK_W-1:0]     tick_q, tick_d;
  logic [US_W-1:0]       us_q, us_d;
  logic [CH_W-1:0]       fcnt_q, fcnt_d;
  logic [ADDR_WIDTH-1:0] step_q, step_d, len_q, len_d;
  logic [7:0]            hold_q, hold_d, fleft_q, fleft_d;
  logic                  run_q, run_d, end_q, end_d, done_q, done_d;
  logic [NUM_CH-1:0]     pwm_q, pwm_d;
  logic [DATA_WIDTH-1:0] tgt_q [NUM_CH];
  logic [DATA_WIDTH-1:0] tgt_d [NUM_CH];
  logic [DATA_WIDTH-1:0] pos_q [NUM_CH];
  logic [DATA_WIDTH-1:0] pos_d [NUM_CH];
  logic [DATA_WIDTH-1:0] pos_adv [NUM_CH];
  logic                  tick, boundary, trigger, last_step;

`ifdef SERVO_SEQ_SLEW_EN
  function automatic logic [DATA_WIDTH-1:0] slew(input logic [DATA_WIDTH-1:0] cur,
                                                 input logic [DATA_WIDTH-1:0] tgt);
    if (int'(tgt) > int'(cur) + SLEW_STEP) return DATA_WIDTH'(int'(cur) + SLEW_STEP);
    if (int'(tgt) + SLEW_STEP < int'(cur)) return DATA_WIDTH'(int'(cur) - SLEW_STEP);
    return tgt;
  endfunction
`endif

  assign tick      = run_q && (tick_q == TICK_W'(DIV - 1));
  assign boundary  = tick && (us_q == US_W'(FRAME_US - 1));
  assign trigger   = (state_q == S_RUN) && tick && (us_q == US_W'(PW_MAX)) &&
                     (fleft_q == 8'd1) && !end_q;
  assign last_step = (step_q == len_q - 1'b1);

  assign busy     = (state_q != S_IDLE);
  assign step_idx = step_q;
  assign done     = done_q;
  assign pwm_out  = pwm_q;

  // Capture fetched data into the target registers one cycle after each read.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      tgt_d[c] = tgt_q[c];
      if (state_q == S_FETCH && int'(fcnt_q) == c + 1) tgt_d[c] = mem_data;
    end
  end

  // Position each channel takes when the next frame starts.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
`ifdef SERVO_SEQ_SLEW_EN
      pos_adv[c] = slew(pos_q[c], tgt_d[c]);
`else
      pos_adv[c] = tgt_d[c];
`endif
    end
  end

  // Sequencer FSM, frame timing and PWM next-state.
  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    us_d     = us_q;
    fcnt_d   = fcnt_q;
    step_d   = step_q;
    len_d    = len_q;
    hold_d   = hold_q;
    fleft_d  = fleft_q;
    run_d    = run_q;
    end_d    = end_q;
    done_d   = 1'b0;
    pos_d    = pos_q;
    mem_rd   = 1'b0;
    mem_addr = '0;

    if (run_q) begin
      tick_d = tick ? '0 : tick_q + 1'b1;
      if (tick) us_d = boundary ? '0 : us_q + 1'b1;
    end

    if (state_q == S_FETCH) begin
      if (fcnt_q < CH_W'(NUM_CH)) begin
        mem_rd   = 1'b1;
        mem_addr = ADDR_WIDTH'(int'(step_q) * NUM_CH + int'(fcnt_q));
      end
      fcnt_d = fcnt_q + 1'b1;
      if (fcnt_q == CH_W'(NUM_CH)) begin
        state_d = S_RUN;
        fcnt_d  = '0;
        // First fetch of a playback: open a fresh frame immediately.
        if (!run_q) begin
          run_d   = 1'b1;
          tick_d  = '0;
          us_d    = '0;
          fleft_d = hold_q;
          pos_d   = pos_adv;
        end
      end
    end

    if (boundary) begin
      if (fleft_q == 8'd1 && end_q) begin
        state_d = S_IDLE;
        run_d   = 1'b0;
        end_d   = 1'b0;
        done_d  = 1'b1;
        tick_d  = '0;
        us_d    = '0;
      end else begin
        pos_d   = pos_adv;
        fleft_d = (fleft_q == 8'd1) ? hold_q : fleft_q - 1'b1;
      end
    end

    if (trigger) begin
      if (!last_step) begin
        step_d  = step_q + 1'b1;
        state_d = S_FETCH;
      end else if (loop) begin
        step_d  = '0;
        state_d = S_FETCH;
      end else begin
        end_d = 1'b1;
      end
    end

    if (state_q == S_IDLE && start) begin
      if (seq_len == '0) begin
        done_d = 1'b1;
      end else begin
        state_d = S_FETCH;
        len_d   = seq_len;
        hold_d  = (hold_frames == 8'd0) ? 8'd1 : hold_frames;
        step_d  = '0;
        fcnt_d  = '0;
        end_d   = 1'b0;
        run_d   = 1'b0;
      end
    end

    if (stop) begin
      state_d = S_IDLE;
      run_d   = 1'b0;
      tick_d  = '0;
      us_d    = '0;
      step_d  = '0;
      fcnt_d  = '0;
      end_d   = 1'b0;
      done_d  = 1'b0;
    end

    for (int c = 0; c < NUM_CH; c++) begin
      pwm_d[c] = run_d && (int'(us_d) < 1000 + 4 * int'(pos_d[c]));
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      us_q    <= '0;
      fcnt_q  <= '0;
      step_q  <= '0;
      len_q   <= '0;
      hold_q  <= '0;
      fleft_q <= '0;
      run_q   <= 1'b0;
      end_q   <= 1'b0;
      done_q  <= 1'b0;
      pwm_q   <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        tgt_q[c] <= '0;
        pos_q[c] <= '0;
      end
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      us_q    <= us_d;
      fcnt_q  <= fcnt_d;
      step_q  <= step_d;
      len_q   <= len_d;
      hold_q  <= hold_d;
      fleft_q <= fleft_d;
      run_q   <= run_d;
      end_q   <= end_d;
      done_q  <= done_d;
      pwm_q   <= pwm_d;
      tgt_q   <= tgt_d;
      pos_q   <= pos_d;
    end
  end
endmodule

// File: tb/tb_servo_seq.sv
// tb_servo_seq: directed, table-driven bench for servo_seq with a 1 MHz clock
// (one cycle per microsecond) and a 4000 us frame.
module tb_servo_seq;
  localparam int FR = 4000;

  typedef struct {
    logic [7:0] v0, v1, v2;
    int hold, nfr, poke;
    int w0, w1, w2;
  } vec_t;

  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, stop = 1'b0, loop = 1'b0;
  logic [7:0] seq_len = 8'd0, hold_frames = 8'd0, mem_data = 8'd0;
  logic [7:0] mem_addr, step_idx;
  logic       mem_rd, busy, done;
  logic [2:0] pwm_out;
  logic [7:0] mem [256];
  logic [7:0] addr_log [$];
  logic [7:0] step_log [$];
  int         n_tests = 0, n_fail = 0;
  int         wid [8][3];
  int         lat;
  vec_t       vt [4];

  servo_seq #(.NUM_CH(3), .DATA_WIDTH(8), .ADDR_WIDTH(8), .CLK_HZ(1000000),
              .FRAME_US(FR), .SLEW_STEP(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop(loop),
    .seq_len(seq_len), .hold_frames(hold_frames), .mem_rd(mem_rd),
    .mem_addr(mem_addr), .mem_data(mem_data), .pwm_out(pwm_out), .busy(busy),
    .step_idx(step_idx), .done(done));

  always #5 clk = ~clk;

  // Synchronous memory: data one cycle after the read strobe.
  always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish, required finish before timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step_cycle();
    if (mem_rd === 1'b1) addr_log.push_back(mem_addr);
    if (step_log.size() == 0 || step_log[$] != step_idx) step_log.push_back(step_idx);
    @(negedge clk);
  endtask

  task automatic kick(input int len, input int hold, input logic lp);
    seq_len     = 8'(len);
    hold_frames = 8'(hold);
    loop        = lp;
    start       = 1'b1;
    step_cycle();
    start       = 1'b0;
  endtask

  // Wait for the first frame to open, then count high cycles per channel.
  task automatic measure(input int nframes, input int poke);
    int waited = 0;
    while (pwm_out[0] !== 1'b1 && waited < 20) begin
      step_cycle();
      waited++;
    end
    lat = waited;
    if (waited >= 20) begin
      n_tests++;
      n_fail++;
      $display("FAIL frame_start: no pulse within %0d cycles, required within 20", waited);
      return;
    end
    for (int f = 0; f < 8; f++) for (int c = 0; c < 3; c++) wid[f][c] = 0;
    for (int f = 0; f < nframes; f++) begin
      for (int i = 0; i < FR; i++) begin
        for (int c = 0; c < 3; c++) if (pwm_out[c] === 1'b1) wid[f][c]++;
        if (f * FR + i == poke) begin
          start       = 1'b1;
          seq_len     = 8'd5;
          hold_frames = 8'd9;
        end else begin
          start = 1'b0;
        end
        step_cycle();
      end
    end
    start = 1'b0;
  endtask

  initial begin
    int exp_sl [6];
    int exp_addr [12];
    int exp_step [4];
    int dcount;
    vt[0] = '{8'd0,   8'd128, 8'd255, 2, 2, -1,  1000, 1512, 2020};
    vt[1] = '{8'd1,   8'd64,  8'd200, 1, 1, -1,  1004, 1256, 1800};
    vt[2] = '{8'd255, 8'd0,   8'd17,  1, 1, -1,  2020, 1000, 1068};
    vt[3] = '{8'd10,  8'd20,  8'd30,  0, 1, 100, 1040, 1080, 1120};
`ifdef SERVO_SEQ_SLEW_EN
    exp_sl = '{1016, 1032, 1048, 1064, 1080, 1080};
`else
    exp_sl = '{1080, 1080, 1080, 1080, 1080, 1080};
`endif
    exp_addr = '{0, 1, 2, 3, 4, 5, 0, 1, 2, 3, 4, 5};
    exp_step = '{0, 1, 0, 1};
    for (int a = 0; a < 256; a++) mem[a] = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_state", 32'({pwm_out, busy, done, mem_rd, mem_addr, step_idx}), 32'd0);
    rst_n = 1'b1;
    step_cycle();

    // Empty sequence: done pulse only
    kick(0, 1, 1'b0);
    check("len0_done", 32'(done), 32'd1);
    check("len0_busy", 32'(busy), 32'd0);
    check("len0_rd", 32'(mem_rd), 32'd0);
    step_cycle();
    check("len0_done_clr", 32'(done), 32'd0);
    check("len0_rd2", 32'(mem_rd), 32'd0);

    // Single-step sequences from the table
    for (int r = 0; r < 4; r++) begin
      mem[0] = vt[r].v0;
      mem[1] = vt[r].v1;
      mem[2] = vt[r].v2;
      kick(1, vt[r].hold, 1'b0);
      measure(vt[r].nfr, vt[r].poke);
      check($sformatf("v%0d_latency", r), 32'(lat), 32'd4);
`ifndef SERVO_SEQ_SLEW_EN
      for (int f = 0; f < vt[r].nfr; f++) begin
        check($sformatf("v%0d_f%0d_ch0", r, f), 32'(wid[f][0]), 32'(vt[r].w0));
        check($sformatf("v%0d_f%0d_ch1", r, f), 32'(wid[f][1]), 32'(vt[r].w1));
        check($sformatf("v%0d_f%0d_ch2", r, f), 32'(wid[f][2]), 32'(vt[r].w2));
      end
`endif
      check($sformatf("v%0d_done", r), 32'(done), 32'd1);
      check($sformatf("v%0d_busy", r), 32'(busy), 32'd0);
      check($sformatf("v%0d_pwm_end", r), 32'(pwm_out), 32'd0);
      check($sformatf("v%0d_step", r), 32'(step_idx), 32'd0);
      step_cycle();
      check($sformatf("v%0d_done_clr", r), 32'(done), 32'd0);
    end

    // Two-step looping sequence: addresses, step order, unbroken frames
    mem[0] = 8'd5;  mem[1] = 8'd6;  mem[2] = 8'd7;
    mem[3] = 8'd50; mem[4] = 8'd60; mem[5] = 8'd70;
    addr_log.delete();
    step_log.delete();
    kick(2, 1, 1'b1);
    measure(3, -1);
    check("loop_latency", 32'(lat), 32'd4);
    check("loop_addr_cnt", 32'(addr_log.size()), 32'd12);
    for (int k = 0; k < 12; k++)
      if (k < addr_log.size()) check($sformatf("loop_addr%0d", k), 32'(addr_log[k]), 32'(exp_addr[k]));
    check("loop_step_cnt", 32'(step_log.size()), 32'd4);
    for (int k = 0; k < 4; k++)
      if (k < step_log.size()) check($sformatf("loop_step%0d", k), 32'(step_log[k]), 32'(exp_step[k]));
`ifndef SERVO_SEQ_SLEW_EN
    check("loop_f0_ch0", 32'(wid[0][0]), 32'd1020);
    check("loop_f0_ch2", 32'(wid[0][2]), 32'd1028);
    check("loop_f1_ch0", 32'(wid[1][0]), 32'd1200);
    check("loop_f1_ch1", 32'(wid[1][1]), 32'd1240);
    check("loop_f1_ch2", 32'(wid[1][2]), 32'd1280);
    check("loop_f2_ch1", 32'(wid[2][1]), 32'd1024);
`endif
    check("loop_busy", 32'(busy), 32'd1);
    stop = 1'b1;
    step_cycle();
    stop = 1'b0;
    check("loop_stop_busy", 32'(busy), 32'd0);
    check("loop_stop_step", 32'(step_idx), 32'd0);

    // Stop 500 us into a frame
    mem[0] = 8'd100; mem[1] = 8'd100; mem[2] = 8'd100;
    kick(1, 5, 1'b0);
    measure(0, -1);
    repeat (500) step_cycle();
    check("stop_pre_pwm", 32'(pwm_out), 32'd7);
    stop = 1'b1;
    step_cycle();
    stop = 1'b0;
    check("stop_pwm", 32'(pwm_out), 32'd0);
    check("stop_busy", 32'(busy), 32'd0);
    check("stop_step", 32'(step_idx), 32'd0);
    dcount = 0;
    for (int k = 0; k < 10; k++) begin
      if (done === 1'b1) dcount++;
      step_cycle();
    end
    check("stop_no_done", 32'(dcount), 32'd0);

    // Stop and start together: stop wins
    seq_len = 8'd1; start = 1'b1; stop = 1'b1;
    step_cycle();
    start = 1'b0; stop = 1'b0;
    check("stopstart_busy", 32'(busy), 32'd0);
    check("stopstart_done", 32'(done), 32'd0);
    seq_len = 8'd0; start = 1'b1; stop = 1'b1;
    step_cycle();
    start = 1'b0; stop = 1'b0;
    check("stopstart0_done", 32'(done), 32'd0);

    // Asynchronous reset in the middle of a fetch
    mem[1] = 8'd77;
    kick(1, 1, 1'b0);
    step_cycle();
    check("fetch_pre_rd", 32'({mem_rd, mem_addr}), 32'({1'b1, 8'd1}));
    rst_n = 1'b0;
    #1;
    check("fetch_rst", 32'({pwm_out, busy, done, mem_rd, mem_addr, step_idx}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step_cycle();
    check("fetch_rst_idle", 32'(busy), 32'd0);

    // Position change from 0 to 20 over six frames
    mem[0] = 8'd20; mem[1] = 8'd0; mem[2] = 8'd0;
    kick(1, 6, 1'b0);
    measure(6, -1);
    for (int f = 0; f < 6; f++) begin
      check($sformatf("slew_f%0d_ch0", f), 32'(wid[f][0]), 32'(exp_sl[f]));
      check($sformatf("slew_f%0d_ch1", f), 32'(wid[f][1]), 32'd1000);
    end
    check("slew_done", 32'(done), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
